// File: rtl/marcador_led.sv
// marcador_led: drives four score LEDs from a score counter.
// The LEDs show a thermometer of the score, blank briefly after every score
// change, and run a blink animation followed by a steady all-on display
// while the winner flag is held.
// Inputs are registered once before any decision is made, so an input change
// reaches the LEDs two clock1k edges later.
module marcador_led #(
    parameter int T_DESTELLO  = 100,
    parameter int PERIODO     = 250,
    parameter int N_PARPADEOS = 4
) (
    input  logic       clock1k,
    input  logic       reset,
    input  logic [1:0] counTT,
    input  logic       GanadorTT,
    output logic [3:0] LED,
    output logic       Celebrando,
    output logic       Cambio
);

    typedef enum logic [1:0] {
        MOSTRAR  = 2'd0,
        DESTELLO = 2'd1,
        GANADOR  = 2'd2,
        FIN      = 2'd3
    } estado_t;

    // Last timer value of the blank window and of each blink half-period.
    localparam logic [15:0] T_ULTIMO = 16'(T_DESTELLO - 1);
    localparam logic [15:0] P_ULTIMO = 16'(PERIODO - 1);
    // Number of half-periods in the whole animation (on + off per blink).
    localparam logic [8:0]  N_MEDIOS = 9'(2 * N_PARPADEOS);

    // Input pipeline: cnt_r/gan_r are the sampled inputs, *_ant one cycle older.
    logic [1:0] cnt_r;
    logic [1:0] cnt_ant;
    logic       gan_r;
    logic       gan_ant;

    estado_t    estado;
    estado_t    estado_sig;
    logic [15:0] timer;
    logic [15:0] timer_sig;
    logic [15:0] timer_inc;
    logic [8:0]  blink;
    logic [8:0]  blink_sig;
    logic [3:0]  led_sig;
    logic        cambio_sig;
    logic        celebrando_sig;

    logic subida;
    logic cambio_cnt;
    logic acepta_cambio;
    logic fin_blanco;
    logic fin_medio;

    // Thermometer code of the score: n lowest LEDs lit.
    function automatic logic [3:0] termometro(input logic [1:0] n);
        logic [3:0] t;
        case (n)
            2'd0:    t = 4'b0000;
            2'd1:    t = 4'b0001;
            2'd2:    t = 4'b0011;
            default: t = 4'b0111;
        endcase
        return t;
    endfunction

    assign subida     = gan_r & ~gan_ant;
    assign cambio_cnt = (cnt_r != cnt_ant);
    assign fin_blanco = (timer == T_ULTIMO);
    assign fin_medio  = (timer == P_ULTIMO);
    // Timer saturates instead of wrapping.
    assign timer_inc  = (timer == 16'hFFFF) ? timer : timer + 16'd1;
    // A score change counts only while showing or blanking, and a winner
    // edge in the same cycle takes precedence.
    assign acepta_cambio = ((estado == MOSTRAR) || (estado == DESTELLO))
                           && !subida && cambio_cnt;

    // Input sampling registers and their one-cycle history.
    always_ff @(posedge clock1k or negedge reset) begin
        if (!reset) begin
            cnt_r   <= 2'd0;
            cnt_ant <= 2'd0;
            gan_r   <= 1'b0;
            gan_ant <= 1'b0;
        end else begin
            cnt_r   <= counTT;
            cnt_ant <= cnt_r;
            gan_r   <= GanadorTT;
            gan_ant <= gan_r;
        end
    end

    // State, counters and registered outputs all update on the same edge.
    always_ff @(posedge clock1k or negedge reset) begin
        if (!reset) begin
            estado     <= MOSTRAR;
            timer      <= 16'd0;
            blink      <= 9'd0;
            LED        <= 4'b0000;
            Celebrando <= 1'b0;
            Cambio     <= 1'b0;
        end else begin
            estado     <= estado_sig;
            timer      <= timer_sig;
            blink      <= blink_sig;
            LED        <= led_sig;
            Celebrando <= celebrando_sig;
            Cambio     <= cambio_sig;
        end
    end

    // Next state plus timer and blink counter updates.
    always_comb begin
        estado_sig = estado;
        timer_sig  = timer_inc;
        blink_sig  = blink;
        case (estado)
            MOSTRAR: begin
                timer_sig = 16'd0;
                if (subida) begin
                    estado_sig = GANADOR;
                    blink_sig  = 9'd0;
                end else if (cambio_cnt) begin
                    estado_sig = DESTELLO;
                end
            end
            DESTELLO: begin
                if (subida) begin
                    estado_sig = GANADOR;
                    timer_sig  = 16'd0;
                    blink_sig  = 9'd0;
                end else if (cambio_cnt) begin
                    timer_sig  = 16'd0;
                end else if (fin_blanco) begin
                    estado_sig = MOSTRAR;
                    timer_sig  = 16'd0;
                end
            end
            GANADOR: begin
                if (!gan_r) begin
                    estado_sig = MOSTRAR;
                    timer_sig  = 16'd0;
                    blink_sig  = 9'd0;
                end else if (fin_medio) begin
                    timer_sig = 16'd0;
                    blink_sig = blink + 9'd1;
                    if ((blink + 9'd1) == N_MEDIOS) begin
                        estado_sig = FIN;
                    end
                end
            end
            FIN: begin
                timer_sig = 16'd0;
                if (!gan_r) begin
                    estado_sig = MOSTRAR;
                    blink_sig  = 9'd0;
                end
            end
            default: begin
                estado_sig = MOSTRAR;
                timer_sig  = 16'd0;
                blink_sig  = 9'd0;
            end
        endcase
    end

    // Next LED pattern and status flags, derived from the state being entered.
    always_comb begin
        led_sig        = LED;
        cambio_sig     = acepta_cambio;
        celebrando_sig = (estado_sig == GANADOR) || (estado_sig == FIN);
        case (estado_sig)
            MOSTRAR:  led_sig = termometro(cnt_r);
            DESTELLO: led_sig = 4'b0000;
            GANADOR: begin
                if (estado != GANADOR) begin
                    led_sig = 4'b1111;
                end else if (fin_medio) begin
                    led_sig = ~LED;
                end
            end
            FIN:      led_sig = 4'b1111;
            default:  led_sig = 4'b0000;
        endcase
    end

endmodule

// File: tb/tb_marcador_led.sv
// Bench for marcador_led: directed score/winner sequences with literal
// expectations at key cycles, plus a cycle-level behavioural model compared
// against the DUT on every falling clock edge.
module tb_marcador_led;

    localparam int TD  = 3;
    localparam int PER = 4;
    localparam int NP  = 2;

    logic       clock1k;
    logic       reset;
    logic [1:0] counTT;
    logic       GanadorTT;
    logic [3:0] LED;
    logic       Celebrando;
    logic       Cambio;

    int n_cmp = 0;
    int n_bad = 0;

    marcador_led #(
        .T_DESTELLO (TD),
        .PERIODO    (PER),
        .N_PARPADEOS(NP)
    ) dut (
        .clock1k   (clock1k),
        .reset     (reset),
        .counTT    (counTT),
        .GanadorTT (GanadorTT),
        .LED       (LED),
        .Celebrando(Celebrando),
        .Cambio    (Cambio)
    );

    // Clock and watchdog
    initial begin
        clock1k = 1'b0;
        forever #5 clock1k = ~clock1k;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, required finish before t=100000");
        $fatal(1, "watchdog expired");
    end

    // Behavioural model: mode 0 shows the score, mode 1 blanks for TD cycles
    // after a change, mode 2 is the winner display (blink then steady on),
    // described by the number of cycles since the winner display started.
    int         m_mode = 0;
    int         m_age  = 0;
    logic [1:0] m_cnt1 = 2'd0;
    logic [1:0] m_cnt2 = 2'd0;
    logic       m_gan1 = 1'b0;
    logic       m_gan2 = 1'b0;
    logic [3:0] exp_led = 4'b0000;
    logic       exp_cel = 1'b0;
    logic       exp_cam = 1'b0;

    initial begin
        forever begin
            @(posedge clock1k or negedge reset);
            if (!reset) begin
                m_mode = 0; m_age = 0;
                m_cnt1 = 2'd0; m_cnt2 = 2'd0; m_gan1 = 1'b0; m_gan2 = 1'b0;
                exp_led = 4'b0000; exp_cel = 1'b0; exp_cam = 1'b0;
            end else begin
                exp_cam = 1'b0;
                if (m_mode != 2) begin
                    if (m_gan1 && !m_gan2) begin
                        m_mode = 2; m_age = 0;
                    end else if (m_cnt1 != m_cnt2) begin
                        m_mode = 1; m_age = 0; exp_cam = 1'b1;
                    end else if (m_mode == 1) begin
                        m_age = m_age + 1;
                        if (m_age >= TD) m_mode = 0;
                    end
                end else begin
                    if (!m_gan1) m_mode = 0;
                    else if (m_age < 1000000) m_age = m_age + 1;
                end
                case (m_mode)
                    0: exp_led = 4'((1 << m_cnt1) - 1);
                    1: exp_led = 4'b0000;
                    default: begin
                        if (m_age < 2 * NP * PER)
                            exp_led = (((m_age / PER) % 2) == 0) ? 4'b1111 : 4'b0000;
                        else
                            exp_led = 4'b1111;
                    end
                endcase
                exp_cel = (m_mode == 2);
                m_cnt2 = m_cnt1; m_cnt1 = counTT;
                m_gan2 = m_gan1; m_gan1 = GanadorTT;
            end
        end
    end

    // Scoreboard compare against the model, away from the active edge
    initial begin
        forever begin
            @(negedge clock1k);
            n_cmp++;
            if ({LED, Celebrando, Cambio} !== {exp_led, exp_cel, exp_cam}) begin
                n_bad++;
                $display("FAIL model t=%0t: got led=%b cel=%b cam=%b, required led=%b cel=%b cam=%b",
                         $time, LED, Celebrando, Cambio, exp_led, exp_cel, exp_cam);
            end
        end
    end

    // Driver tasks
    task automatic step();
        @(posedge clock1k);
        #1;
    endtask

    task automatic check_lit(input string name, input logic [5:0] exp);
        n_cmp++;
        if ({LED, Celebrando, Cambio} !== exp) begin
            n_bad++;
            $display("FAIL %s: got led=%b cel=%b cam=%b, required led=%b cel=%b cam=%b",
                     name, LED, Celebrando, Cambio, exp[5:2], exp[1], exp[0]);
        end
    endtask

    // Directed scenarios
    initial begin
        reset = 1'b0; counTT = 2'd0; GanadorTT = 1'b0;
        step(); step();
        check_lit("reset_state", 6'b0000_0_0);
        reset = 1'b1;
        repeat (3) step();
        check_lit("idle_zero", 6'b0000_0_0);

        // Score step 0 -> 2
        counTT = 2'd2;
        step(); check_lit("step_k1",     6'b0000_0_0);
        step(); check_lit("step_cambio", 6'b0000_0_1);
        step(); check_lit("step_blank1", 6'b0000_0_0);
        step(); check_lit("step_blank2", 6'b0000_0_0);
        step(); check_lit("step_show",   6'b0011_0_0);
        step(); check_lit("step_nopulse", 6'b0011_0_0);

        // Retrigger 1 -> 2 -> 1
        counTT = 2'd1;
        repeat (8) step();
        check_lit("settle_1", 6'b0001_0_0);
        counTT = 2'd2;
        step();
        step(); check_lit("retrig_p1", 6'b0000_0_1);
        counTT = 2'd1;
        step(); check_lit("retrig_gap", 6'b0000_0_0);
        step(); check_lit("retrig_p2", 6'b0000_0_1);
        step(); check_lit("retrig_b1", 6'b0000_0_0);
        step(); check_lit("retrig_b2", 6'b0000_0_0);
        step(); check_lit("retrig_show", 6'b0001_0_0);

        // Win animation, score change ignored in FIN, exit on flag drop
        counTT = 2'd3;
        repeat (8) step();
        check_lit("settle_3", 6'b0111_0_0);
        GanadorTT = 1'b1;
        step(); check_lit("win_k1",    6'b0111_0_0);
        step(); check_lit("win_entry", 6'b1111_1_0);
        for (int e = 3; e <= 25; e++) begin
            step();
            case (e)
                5:  check_lit("win_on_last",  6'b1111_1_0);
                6:  check_lit("win_off1",     6'b0000_1_0);
                10: check_lit("win_on2",      6'b1111_1_0);
                14: check_lit("win_off2",     6'b0000_1_0);
                17: check_lit("win_off2_end", 6'b0000_1_0);
                18: check_lit("fin_entry",    6'b1111_1_0);
                25: check_lit("fin_ignore_score", 6'b1111_1_0);
                default: ;
            endcase
            if (e == 20) counTT = 2'd1;
        end
        GanadorTT = 1'b0;
        step(); check_lit("fin_j1",   6'b1111_1_0);
        step(); check_lit("fin_exit", 6'b0001_0_0);

        // Abort during the second half-period
        repeat (3) step();
        GanadorTT = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            step();
            case (e)
                2: check_lit("abort_entry", 6'b1111_1_0);
                6: check_lit("abort_off",   6'b0000_1_0);
                8: check_lit("abort_hold",  6'b0000_1_0);
                9: check_lit("abort_show",  6'b0001_0_0);
                default: ;
            endcase
            if (e == 7) GanadorTT = 1'b0;
        end

        // Asynchronous reset mid-animation, release with counTT=1
        repeat (3) step();
        GanadorTT = 1'b1;
        repeat (4) step();
        check_lit("pre_reset", 6'b1111_1_0);
        #2;
        reset = 1'b0;
        #1;
        check_lit("async_reset", 6'b0000_0_0);
        GanadorTT = 1'b0;
        counTT = 2'd1;
        step(); step();
        check_lit("reset_hold", 6'b0000_0_0);
        reset = 1'b1;
        step(); check_lit("rel_sample", 6'b0000_0_0);
        step(); check_lit("rel_cambio", 6'b0000_0_1);
        step(); check_lit("rel_b1",     6'b0000_0_0);
        step(); check_lit("rel_b2",     6'b0000_0_0);
        step(); check_lit("rel_show",   6'b0001_0_0);
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
